batch_reverser: RTL and testbench

- Ping-pong buffer that sits directly upstream of the backward recursion stage of the estimation filter.
- Collects digital control samples (N-bit control vectors) into fixed-length batches and replays each completed batch in time-reversed order.
- Its out_first flag marks the start of each reversed batch, so the backward recursion can load its reset/initial value there.
- Input and output run in lockstep: one sample written per accepted input, one reversed sample emitted per accepted input once primed.

---
 rtl/batch_reverser.sv | 77 +++++++
 tb/tb_batch_reverser.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/batch_reverser.sv
// Ping-pong batch buffer: captures DEPTH-sample batches of N-bit control vectors
// and replays each completed batch newest-first, in lockstep with the input stream.
module batch_reverser #(
    parameter int N     = 3,
    parameter int DEPTH = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] in_bits,
    output logic         out_valid,
    output logic [N-1:0] out_bits,
    output logic         out_first,
    output logic         out_last,
    output logic         primed
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [N-1:0]  bank0 [DEPTH];
    logic [N-1:0]  bank1 [DEPTH];
    logic          wr_bank;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] rd_idx;
    logic [N-1:0]  rd_data;
    logic          wrap;

    // Handshake: in_valid is the sole advance condition (no ready; every input is
    // accepted); out_valid marks a one-cycle sample the consumer must take.
    assign wrap    = (wr_cnt == LAST_IDX);
    assign rd_idx  = LAST_IDX - wr_cnt;
    assign rd_data = wr_bank ? bank0[rd_idx] : bank1[rd_idx];

    // Storage has no reset so it maps onto plain RAM; stale data is never read
    // because primed gates every readout.
    always_ff @(posedge clk) begin
        if (rst && in_valid) begin
            if (wr_bank) bank1[wr_cnt] <= in_bits;
            else         bank0[wr_cnt] <= in_bits;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_bank   <= 1'b0;
            wr_cnt    <= '0;
            primed    <= 1'b0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_bits  <= '0;
        end else begin
            if (in_valid) begin
                if (wrap) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                    primed  <= 1'b1;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            // Read side uses pre-update write state, so it always targets the other bank.
            if (in_valid && primed) begin
                out_valid <= 1'b1;
                out_bits  <= rd_data;
                out_first <= (wr_cnt == '0);
                out_last  <= wrap;
            end else begin
                out_valid <= 1'b0;
                out_first <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_batch_reverser.sv
// Bench for batch_reverser: one stimulus stream drives DEPTH=4, 2 and 64 instances,
// each checked every cycle against a history-based reference model.
module tb_batch_reverser;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [2:0] in_bits;
    logic [2:0] ov, of, ol, pr;
    logic [2:0] ob [3];

    int dep [3] = '{4, 2, 64};

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    // Reference model state: every accepted sample since reset, plus expected outputs.
    logic [2:0] hist [$];
    logic [2:0] e_v, e_f, e_l, e_p;
    logic [2:0] e_b [3];

    batch_reverser #(.N(3), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bits(in_bits),
        .out_valid(ov[0]), .out_bits(ob[0]), .out_first(of[0]), .out_last(ol[0]), .primed(pr[0])
    );
    batch_reverser #(.N(3), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bits(in_bits),
        .out_valid(ov[1]), .out_bits(ob[1]), .out_first(of[1]), .out_last(ol[1]), .primed(pr[1])
    );
    batch_reverser #(.N(3), .DEPTH(64)) u_d64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bits(in_bits),
        .out_valid(ov[2]), .out_bits(ob[2]), .out_first(of[2]), .out_last(ol[2]), .primed(pr[2])
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- drivers + model ----------------
    task automatic reset_dut(input int cycles);
        rst = 1'b0;
        repeat (cycles) begin
            in_valid = 1'($urandom_range(0, 1));
            in_bits  = 3'($urandom);
            @(posedge clk);
            #1;
            hist.delete();
            e_v = '0; e_f = '0; e_l = '0; e_p = '0;
            for (int k = 0; k < 3; k++) e_b[k] = '0;
        end
        rst      = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic step(input logic v, input logic [2:0] d);
        int c, p, b, dd;
        in_valid = v;
        in_bits  = d;
        @(posedge clk);
        #1;
        c = hist.size();
        for (int k = 0; k < 3; k++) begin
            dd = dep[k];
            if (v && c >= dd) begin
                p = c % dd;
                b = c / dd;
                e_v[k] = 1'b1;
                e_b[k] = hist[(b - 1) * dd + (dd - 1 - p)];
                e_f[k] = (p == 0);
                e_l[k] = (p == dd - 1);
            end else begin
                e_v[k] = 1'b0;
                e_f[k] = 1'b0;
                e_l[k] = 1'b0;
            end
        end
        if (v) hist.push_back(d);
        for (int k = 0; k < 3; k++) e_p[k] = (hist.size() >= dep[k]);
        in_valid = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                n_cmp += 5;
                if (ov[k] !== e_v[k]) begin
                    n_err++;
                    $display("FAIL sb_valid d%0d t=%0t: got %b expected %b", dep[k], $time, ov[k], e_v[k]);
                end
                if (ob[k] !== e_b[k]) begin
                    n_err++;
                    $display("FAIL sb_bits d%0d t=%0t: got %0d expected %0d", dep[k], $time, ob[k], e_b[k]);
                end
                if (of[k] !== e_f[k]) begin
                    n_err++;
                    $display("FAIL sb_first d%0d t=%0t: got %b expected %b", dep[k], $time, of[k], e_f[k]);
                end
                if (ol[k] !== e_l[k]) begin
                    n_err++;
                    $display("FAIL sb_last d%0d t=%0t: got %b expected %b", dep[k], $time, ol[k], e_l[k]);
                end
                if (pr[k] !== e_p[k]) begin
                    n_err++;
                    $display("FAIL sb_primed d%0d t=%0t: got %b expected %b", dep[k], $time, pr[k], e_p[k]);
                end
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_dut(2);
        chk_en = 1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({ov[k], of[k], ol[k], pr[k], ob[k]} !== 7'd0) begin
                n_err++;
                $display("FAIL reset_state d%0d: got %b expected 0", dep[k], {ov[k], of[k], ol[k], pr[k], ob[k]});
            end
        end
    endtask

    task automatic test_continuous();
        logic [2:0] got [$];
        logic [2:0] exp_q [$];
        exp_q = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4};
        reset_dut(2);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 3'(i));
            if (i == 2 || i == 3) begin
                n_cmp++;
                if (pr[0] !== (i == 3)) begin
                    n_err++;
                    $display("FAIL cont_primed input%0d: got %b expected %b", i + 1, pr[0], i == 3);
                end
            end
            if (i == 4) begin
                n_cmp++;
                if (ov[0] !== 1'b1 || of[0] !== 1'b1) begin
                    n_err++;
                    $display("FAIL cont_first_out: got valid=%b first=%b expected 1 1", ov[0], of[0]);
                end
            end
            if (ov[0]) got.push_back(ob[0]);
        end
        n_cmp++;
        if (got != exp_q) begin
            n_err++;
            $display("FAIL cont_sequence: got %p expected %p", got, exp_q);
        end
    endtask

    task automatic test_stalls();
        logic [2:0] got [$];
        logic [2:0] exp_q [$];
        logic [2:0] last_b;
        int         fed;
        exp_q  = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4};
        reset_dut(2);
        last_b = '0;
        fed    = 0;
        for (int cyc = 0; fed < 12; cyc++) begin
            if (cyc % 3 == 2) begin
                step(1'b0, 3'($urandom));
                n_cmp++;
                if (ov[0] !== 1'b0 || ob[0] !== last_b) begin
                    n_err++;
                    $display("FAIL stall_hold cyc%0d: got valid=%b bits=%0d expected 0 %0d", cyc, ov[0], ob[0], last_b);
                end
            end else begin
                step(1'b1, 3'(fed));
                fed++;
                if (ov[0]) begin
                    got.push_back(ob[0]);
                    last_b = ob[0];
                end
            end
        end
        n_cmp++;
        if (got != exp_q) begin
            n_err++;
            $display("FAIL stall_sequence: got %p expected %p", got, exp_q);
        end
    endtask

    task automatic test_mid_reset();
        reset_dut(2);
        for (int i = 0; i < 6; i++) step(1'b1, 3'(i));
        reset_dut(1);
        n_cmp++;
        if ({ov[0], of[0], ol[0], pr[0], ob[0]} !== 7'd0) begin
            n_err++;
            $display("FAIL midreset_clear: got %b expected 0", {ov[0], of[0], ol[0], pr[0], ob[0]});
        end
        for (int i = 7; i >= 4; i--) step(1'b1, 3'(i));
        n_cmp++;
        if (ov[0] !== 1'b0 || pr[0] !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_prime: got valid=%b primed=%b expected 0 1", ov[0], pr[0]);
        end
        step(1'b1, 3'd3);
        n_cmp++;
        if (ov[0] !== 1'b1 || ob[0] !== 3'd4 || of[0] !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_first: got valid=%b bits=%0d first=%b expected 1 4 1", ov[0], ob[0], of[0]);
        end
    endtask

    task automatic test_idle();
        reset_dut(2);
        for (int i = 0; i < 100; i++) step(1'b0, 3'($urandom));
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({ov[k], of[k], ol[k], pr[k], ob[k]} !== 7'd0) begin
                n_err++;
                $display("FAIL idle_quiet d%0d: got %b expected 0", dep[k], {ov[k], of[k], ol[k], pr[k], ob[k]});
            end
        end
    endtask

    task automatic test_depth2();
        logic [2:0] got [$];
        logic [2:0] exp_q [$];
        logic [3:0] flags;
        exp_q = '{3'd2, 3'd1, 3'd4, 3'd3};
        flags = '0;
        reset_dut(2);
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 3'(i));
            if (ov[1]) begin
                if (got.size() < 2) flags[2 * got.size() +: 2] = {of[1], ol[1]};
                got.push_back(ob[1]);
            end
        end
        n_cmp++;
        if (got != exp_q) begin
            n_err++;
            $display("FAIL d2_sequence: got %p expected %p", got, exp_q);
        end
        n_cmp++;
        if (flags !== 4'b0110) begin
            n_err++;
            $display("FAIL d2_flags: got %b expected 0110", flags);
        end
    endtask

    task automatic test_random();
        int n_first, n_last, n_out, fed;
        n_first = 0; n_last = 0; n_out = 0; fed = 0;
        reset_dut(2);
        while (fed < 11 * 64) begin
            if ($urandom_range(0, 3) == 0) begin
                step(1'b0, 3'($urandom));
            end else begin
                step(1'b1, 3'($urandom));
                fed++;
            end
            if (ov[2]) begin
                n_out++;
                if (of[2]) n_first++;
                if (ol[2]) n_last++;
            end
        end
        step(1'b0, 3'd0);
        n_cmp++;
        if (n_out != 640 || n_first != 10 || n_last != 10) begin
            n_err++;
            $display("FAIL rand_batches: got outs=%0d firsts=%0d lasts=%0d expected 640 10 10", n_out, n_first, n_last);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_bits  = '0;
        e_v = '0; e_f = '0; e_l = '0; e_p = '0;
        for (int k = 0; k < 3; k++) e_b[k] = '0;
        test_reset();
        test_continuous();
        test_stalls();
        test_mid_reset();
        test_idle();
        test_depth2();
        test_random();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
